// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage load/store engine.
//   - access size encodings (MEM_B / MEM_H / MEM_W; 2'b11 behaves as word)
//   - fault cause codes reported on fault_cause
//   - FSM state enum of mem_access_unit
//   - is_misaligned(): alignment rule shared by the control path
package mem_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_LD_MIS  = 2'b01;
    localparam logic [1:0] CAUSE_ST_MIS  = 2'b10;
    localparam logic [1:0] CAUSE_BUS_ERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // size[1] set means word (the reserved 2'b11 encoding is a word too).
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        if (size[1]) begin
            mis = (addr_lo != 2'b00);
        end else if (size == MEM_H) begin
            mis = addr_lo[0];
        end else begin
            mis = 1'b0;
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane formatting for a 32-bit data bus.
//   load_dir=0 (store): data_in is LSB-justified store data; data_out is the
//                       value replicated into every lane, strb_out the byte
//                       strobes for the addressed lanes.
//   load_dir=1 (load):  data_in is the raw bus word; data_out is the addressed
//                       byte/half shifted down and sign/zero-extended
//                       (word passes through), strb_out is 0.
// Ports:
//   load_dir     in   direction select
//   size         in   access size (mem_pkg encodings)
//   addr_lo      in   byte offset within the word
//   is_unsigned  in   zero-extend loads
//   data_in      in   32-bit input data
//   data_out     out  32-bit formatted data
//   strb_out     out  4-bit byte strobes
module mem_lane_align
    import mem_pkg::*;
(
    input  logic        load_dir,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [3:0]  strb_out
);

    logic [31:0] shifted;
    logic        ext_b;
    logic        ext_h;

    always_comb begin
        shifted  = data_in >> {addr_lo, 3'b000};
        ext_b    = shifted[7] & ~is_unsigned;
        ext_h    = shifted[15] & ~is_unsigned;
        data_out = '0;
        strb_out = '0;
        if (load_dir) begin
            if (size[1]) begin
                data_out = data_in;
            end else if (size == MEM_H) begin
                data_out = {{16{ext_h}}, shifted[15:0]};
            end else begin
                data_out = {{24{ext_b}}, shifted[7:0]};
            end
        end else begin
            // Replicating the data lets the memory pick any lane by strobe.
            if (size[1]) begin
                data_out = data_in;
                strb_out = 4'b1111;
            end else if (size == MEM_H) begin
                data_out = {2{data_in[15:0]}};
                strb_out = 4'b0011 << addr_lo;
            end else begin
                data_out = {4{data_in[7:0]}};
                strb_out = 4'b0001 << addr_lo;
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine.
// Turns the EX/MEM load/store request into one valid/ready bus transaction,
// formats store data/strobes, aligns and extends load data, stalls the
// pipeline up to MEM for the duration of the access and reports faults.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_mem_ren/in_mem_wen live instruction, load, store (store wins)
//   in_addr, in_wdata, in_size, in_unsigned  access description
//   flush                         kill the current MEM instruction
//   wb_stall                      MEM/WB register cannot take a result
//   dbus_req_*                    bus request channel (valid/ready)
//   dbus_rsp_*                    bus response beat (valid only, no ready)
//   out_rdata, out_done           extended load data, access complete
//   mem_stall                     freeze PC through EX/MEM
//   fault, fault_cause            fault flag/cause, qualified by out_done
//   dbg_state                     current FSM state (mem_state_e encoding)
//
// Handshake: a request transfers on a cycle where dbus_req_valid and
// dbus_req_ready are both high. Once valid rises, valid and every request
// field stay constant until that transfer. Responses have no back-pressure;
// dbus_rsp_valid is only looked at while waiting for a response.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_mem_ren,
    input  logic                in_mem_wen,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic                flush,
    input  logic                wb_stall,
    output logic                dbus_req_valid,
    input  logic                dbus_req_ready,
    output logic [ADDR_W-1:0]   dbus_req_addr,
    output logic                dbus_req_wen,
    output logic [DATA_W-1:0]   dbus_req_wdata,
    output logic [DATA_W/8-1:0] dbus_req_wstrb,
    input  logic                dbus_rsp_valid,
    input  logic [DATA_W-1:0]   dbus_rsp_rdata,
    input  logic                dbus_rsp_err,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                out_done,
    output logic                mem_stall,
    output logic                fault,
    output logic [1:0]          fault_cause,
    output logic [1:0]          dbg_state
);

    mem_state_e          state_q,     state_d;
    logic                kill_q,      kill_d;
    logic                req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]   req_addr_q,  req_addr_d;
    logic                req_wen_q,   req_wen_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [DATA_W/8-1:0] req_wstrb_q, req_wstrb_d;
    logic [1:0]          size_q,      size_d;
    logic [1:0]          addr_lo_q,   addr_lo_d;
    logic                uns_q,       uns_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic                done_q,      done_d;
    logic                fault_q,     fault_d;
    logic [1:0]          cause_q,     cause_d;

    logic                start;
    logic                misaligned;
    logic [31:0]         st_wdata;
    logic [3:0]          st_wstrb;
    logic [31:0]         ld_data;
    logic [3:0]          ld_strb_unused;

    // Store side works on the live EX/MEM inputs so the formatted copy can
    // be captured on the IDLE -> REQ edge.
    mem_lane_align u_st_align (
        .load_dir    (1'b0),
        .size        (in_size),
        .addr_lo     (in_addr[1:0]),
        .is_unsigned (in_unsigned),
        .data_in     (in_wdata),
        .data_out    (st_wdata),
        .strb_out    (st_wstrb)
    );

    // Load side works on the registered copies, since EX/MEM inputs are
    // only trusted at start.
    mem_lane_align u_ld_align (
        .load_dir    (1'b1),
        .size        (size_q),
        .addr_lo     (addr_lo_q),
        .is_unsigned (uns_q),
        .data_in     (dbus_rsp_rdata),
        .data_out    (ld_data),
        .strb_out    (ld_strb_unused)
    );

    assign start      = in_valid & (in_mem_ren | in_mem_wen) & ~flush;
    assign misaligned = is_misaligned(in_size, in_addr[1:0]);

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        size_d      = size_q;
        addr_lo_d   = addr_lo_q;
        uns_d       = uns_q;
        rdata_d     = rdata_q;
        done_d      = done_q;
        fault_d     = fault_q;
        cause_d     = cause_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        // Fault straight away; the bus never sees the access.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        cause_d = in_mem_wen ? CAUSE_ST_MIS : CAUSE_LD_MIS;
                        rdata_d = '0;
                    end else begin
                        state_d     = ST_REQ;
                        kill_d      = 1'b0;
                        req_valid_d = 1'b1;
                        req_addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
                        req_wen_d   = in_mem_wen;
                        req_wdata_d = in_mem_wen ? st_wdata : '0;
                        req_wstrb_d = in_mem_wen ? st_wstrb : '0;
                        size_d      = in_size;
                        addr_lo_d   = in_addr[1:0];
                        uns_d       = in_unsigned;
                    end
                end
            end

            ST_REQ: begin
                // A flush cannot retract the request; remember it instead.
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (dbus_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (dbus_rsp_valid) begin
                    if (kill_q | flush) begin
                        // Response is consumed and dropped.
                        state_d = ST_IDLE;
                        kill_d  = 1'b0;
                        done_d  = 1'b0;
                        fault_d = 1'b0;
                        cause_d = CAUSE_NONE;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        if (dbus_rsp_err) begin
                            fault_d = 1'b1;
                            cause_d = CAUSE_BUS_ERR;
                            rdata_d = '0;
                        end else begin
                            fault_d = 1'b0;
                            cause_d = CAUSE_NONE;
                            rdata_d = req_wen_q ? '0 : ld_data;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (flush || !wb_stall) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                    rdata_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            size_q      <= MEM_B;
            addr_lo_q   <= 2'b00;
            uns_q       <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            size_q      <= size_d;
            addr_lo_q   <= addr_lo_d;
            uns_q       <= uns_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    assign dbus_req_valid = req_valid_q;
    assign dbus_req_addr  = req_addr_q;
    assign dbus_req_wen   = req_wen_q;
    assign dbus_req_wdata = req_wdata_q;
    assign dbus_req_wstrb = req_wstrb_q;

    assign out_rdata   = rdata_q;
    // A flush in DONE kills the instruction, so its completion is hidden.
    assign out_done    = done_q & ~flush;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

    // Released in DONE so EX/MEM advances on the DONE exit edge.
    assign mem_stall = ((state_q == ST_IDLE) & start)
                     | (state_q == ST_REQ)
                     | (state_q == ST_RSP);

    assign dbg_state = state_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts the pipelined load/store request into a valid/ready data-bus transaction: word address, lane-shifted store data and byte strobes.
- Aligns and sign/zero-extends load data, and produces the MEM-stage memory read data.
- Holds the pipeline up to MEM for the duration of the access and reports misalignment and bus faults.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, bus data width; only 32 is supported

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- in_valid  in  1  MEM stage holds a live instruction
- in_mem_ren  in  1  load
- in_mem_wen  in  1  store; takes priority if both ren and wen are set
- in_addr  in  32  byte address (ALU result)
- in_wdata  in  32  store data, LSB-justified
- in_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- in_unsigned  in  1  zero-extend the load
- flush  in  1  kill the current MEM instruction
- wb_stall  in  1  MEM/WB register cannot accept a result
- dbus_req_valid  out  1  bus request
- dbus_req_ready  in  1  bus accepts the request
- dbus_req_addr  out  32  {in_addr[31:2],2'b00}
- dbus_req_wen  out  1  write request
- dbus_req_wdata  out  32  replicated store data
- dbus_req_wstrb  out  4  byte strobes; 0 for loads
- dbus_rsp_valid  in  1  response beat
- dbus_rsp_rdata  in  32  read data
- dbus_rsp_err  in  1  bus error
- out_rdata  out  32  extended load data; 0 for stores
- out_done  out  1  access complete this cycle
- mem_stall  out  1  freeze PC through EX/MEM
- fault  out  1  access faulted (qualified by out_done)
- fault_cause  out  2  01 load misaligned, 10 store misaligned, 11 bus error

Behaviour:
- Reset: clk only; rst is synchronous, active-high. All state and registered outputs take their reset values on the first clk edge with rst=1, and rst aborts any access in flight.
- Reset values:
  - state=IDLE, kill=0.
  - out_rdata=0, out_done=0, fault=0, fault_cause=00.
  - dbus_req_valid=0 and the other request outputs 0.
- States: IDLE, REQ, RSP, DONE.
- start = in_valid & (in_mem_ren | in_mem_wen) & !flush, evaluated in IDLE.
- Misaligned:
  - half with addr[0]=1, or word with addr[1:0]!=0.
  - Next state DONE with fault=1 and the matching cause.
  - No bus request is issued.
- IDLE -> REQ on start when aligned.
  - Address, size, wen, unsigned and the formatted data/strobes are registered at this point.
  - The request is held stable from the registered copies.
- REQ:
  - dbus_req_valid=1.
  - Once asserted, valid is never retracted until ready.
  - REQ -> RSP on dbus_req_ready.
- RSP:
  - dbus_rsp_valid is sampled only in RSP.
  - On dbus_rsp_valid, capture the extended data (or fault 11 if rsp_err) and go to DONE.
- DONE:
  - out_done=1.
  - Stay in DONE while wb_stall=1; outputs are held.
  - Go to IDLE when wb_stall=0.
- mem_stall = (IDLE & start) | REQ | RSP. It is deasserted in DONE, so EX/MEM advances at the DONE exit edge.
- Minimum latency with ready and rsp both immediate: 3 stall cycles, and out_done in the 4th cycle.
- Store formatting:
  - byte: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - half: wdata={2{h}}, wstrb=0011<<addr[1:0].
  - word: wdata=in_wdata, wstrb=1111.
- Load extraction:
  - Shift rdata right by 8*addr[1:0].
  - byte/half: sign-extend, or zero-extend when in_unsigned=1.
  - word: passed through unchanged.
- Flush:
  - In IDLE: no access starts.
  - In REQ/RSP: set kill. The bus transaction still completes (no retraction, response consumed), then go to IDLE with out_done=0 and fault=0.
  - In DONE: go to IDLE with out_done suppressed that cycle.
- A non-memory in_valid instruction gives no stall and no out_done; the downstream register selects the ALU path.

Decomposition:
- Shared package (mem_pkg):
  - size encodings (MEM_B, MEM_H, MEM_W)
  - fault cause codes
  - state enum
- Sub-module mem_lane_align: purely combinational store replication/strobe generation and load shift/extend, instantiated once in each direction.

Test Plan:
- LB, addr 0x1003, unsigned=0, rsp_rdata 0x80FF_FF12, ready and rsp immediate:
  - req_addr 0x1000, wstrb 0.
  - out_rdata 0xFFFF_FF80, out_done in cycle 3 after start, mem_stall high cycles 0-2.
- SH, addr 0x2002, wdata 0x0000_BEEF:
  - wdata 0xBEEF_BEEF, wstrb 1100, req_wen=1.
  - out_done once, out_rdata 0.
- LW, addr 0x3001:
  - no dbus_req_valid, fault=1, cause 01, out_done the next cycle, 1-cycle stall.
- LHU, addr 0x4000, ready held low 5 cycles then rsp_err=1:
  - req fields stable through REQ.
  - fault cause 11 and mem_stall high throughout.
- Flush asserted in RSP on a load:
  - response consumed, out_done never asserted, back to IDLE, the next load starts normally.
- wb_stall high 3 cycles in DONE:
  - out_done and out_rdata held, then IDLE.
  - rst mid-REQ returns all outputs to 0 the following cycle.
